// File: rtl/peripheral_wb_pkg.sv
// Shared constants and types for the Wishbone burst initiator:
// bus widths, cycle-type/burst-type encodings and the FSM state type.
package peripheral_wb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int LEN_W = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/peripheral_wb_adr_gen.sv
// Next-beat address for a Wishbone burst: +4 bytes, with the low bits
// wrapping inside a 4/8/16-word window for the wrap burst types.
module peripheral_wb_adr_gen
  import peripheral_wb_pkg::*;
(
  input  logic [ADR_W-1:0] adr,
  input  logic [1:0]       bte,
  output logic [ADR_W-1:0] next_adr
);

  logic [ADR_W-1:0] inc;

  assign inc = adr + ADR_W'(4);

  // Wrap modes keep the bits above the window and take only the window bits of the increment
  always_comb begin
    next_adr = inc;
    case (bte)
      BTE_WRAP4:  next_adr = {adr[ADR_W-1:4], inc[3:0]};
      BTE_WRAP8:  next_adr = {adr[ADR_W-1:5], inc[4:0]};
      BTE_WRAP16: next_adr = {adr[ADR_W-1:6], inc[5:0]};
      default:    next_adr = inc;
    endcase
  end

endmodule

// File: rtl/peripheral_wb_initiator.sv
// Command-driven Wishbone burst initiator (reads and writes, linear/wrap bursts).
// Optional stall watchdog enabled by defining PERIPHERAL_WB_TIMEOUT_EN.
module peripheral_wb_initiator
  import peripheral_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_bte,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [DAT_W-1:0] wdat,
  output logic             rdat_valid,
  output logic [DAT_W-1:0] rdat,
  output logic             rdat_last,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             we_o,
  output logic [1:0]       bte_o,
  output logic [2:0]       cti_o,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  input  logic             err_i
);

  state_t           state, next_state;
  logic             ready_q;
  logic             we_q;
  logic [ADR_W-1:0] adr_q, next_adr;
  logic [SEL_W-1:0] sel_q;
  logic [LEN_W-1:0] len_q, beat_q;
  logic [1:0]       bte_q;
  logic [DAT_W-1:0] wbuf_q;
  logic             wbuf_valid_q;
  logic             err_q;
  logic             in_bus, final_beat, ack_ok, err_hit, abort_to, cmd_fire, wdat_fire;

  assign in_bus     = (state == BUS);
  assign final_beat = (beat_q == len_q);
  assign stb_o      = in_bus && (!we_q || wbuf_valid_q);
  assign ack_ok     = stb_o && ack_i && !err_i;
  assign err_hit    = stb_o && err_i;
  assign cmd_ready  = ready_q && (state == IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign wdat_ready = in_bus && we_q && (!wbuf_valid_q || ack_ok);
  assign wdat_fire  = wdat_valid && wdat_ready;

  assign cyc_o = in_bus;
  assign adr_o = adr_q;
  assign sel_o = sel_q;
  assign we_o  = we_q;
  assign dat_o = wbuf_q;
  assign bte_o = (in_bus && len_q != '0) ? bte_q : BTE_LINEAR;
  assign cti_o = (!in_bus || len_q == '0) ? CTI_CLASSIC : (final_beat ? CTI_EOB : CTI_INCR);

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;

  peripheral_wb_adr_gen u_adr_gen (
    .adr      (adr_q),
    .bte      (bte_q),
    .next_adr (next_adr)
  );

`ifdef PERIPHERAL_WB_TIMEOUT_EN
  logic [31:0] stall_cnt;
  logic        timeout_q;

  assign abort_to    = stb_o && !ack_i && !err_i && (stall_cnt == TIMEOUT_CYCLES - 32'd1);
  assign rsp_timeout = rsp_valid && timeout_q;

  // The watchdog only advances while strobing; write wait states hold it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_bus || (stb_o && (ack_i || err_i))) stall_cnt <= '0;
      else if (stb_o)                             stall_cnt <= stall_cnt + 32'd1;
      if (cmd_fire)      timeout_q <= 1'b0;
      else if (abort_to) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign abort_to           = 1'b0;
  assign rsp_timeout        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = BUS;
      BUS:     if (err_hit || abort_to || (ack_ok && final_beat)) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ready_q keeps cmd_ready low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      len_q        <= '0;
      bte_q        <= '0;
      beat_q       <= '0;
      wbuf_q       <= '0;
      wbuf_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdat         <= '0;
      rdat_valid   <= 1'b0;
      rdat_last    <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      rdat_valid <= ack_ok && !we_q;
      rdat_last  <= ack_ok && !we_q && final_beat;
      if (ack_ok && !we_q) rdat <= dat_i;

      if (cmd_fire) begin
        we_q   <= cmd_we;
        adr_q  <= cmd_adr;
        sel_q  <= cmd_sel;
        len_q  <= cmd_len;
        bte_q  <= cmd_bte;
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (ack_ok) begin
        adr_q  <= next_adr;
        beat_q <= beat_q + LEN_W'(1);
      end
      if (err_hit) err_q <= 1'b1;

      if (!in_bus) begin
        wbuf_valid_q <= 1'b0;
      end else if (wdat_fire) begin
        wbuf_q       <= wdat;
        wbuf_valid_q <= 1'b1;
      end else if (ack_ok) begin
        wbuf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_wb_initiator.sv
// Self-checking bench for peripheral_wb_initiator: directed scenarios plus
// randomized commands against a beat-level reference model of the bus.
module tb_peripheral_wb_initiator;

  localparam int TO = 8;
`ifdef PERIPHERAL_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel, cmd_len;
  logic [1:0]  cmd_bte;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat, rdat;
  logic        rdat_valid, rdat_last, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o, ack_i, err_i;
  logic [1:0]  bte_o;
  logic [2:0]  cti_o;

  peripheral_wb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len), .cmd_bte(cmd_bte),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat), .rdat_last(rdat_last),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .bte_o(bte_o),
    .cti_o(cti_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdata [16];
  logic [31:0] rdata [16];
  int          rd_cnt;

  bit          c_we, c_spur, c_hang;
  logic [31:0] c_adr;
  logic [3:0]  c_sel;
  logic [1:0]  c_bte;
  int          c_len, c_err_beat, c_wait_lo, c_wait_hi, c_drop_after, c_drop_len, c_rst_beat;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: byte address of beat k, from the start address and wrap window size
  function automatic logic [31:0] exp_adr(input logic [31:0] start, input logic [1:0] bte, input int k);
    int n;
    logic [31:0] span, base;
    case (bte)
      2'b01:   n = 4;
      2'b10:   n = 8;
      2'b11:   n = 16;
      default: n = 0;
    endcase
    if (n == 0) return start + 32'(4 * k);
    span = 32'(4 * n);
    base = start & ~(span - 32'd1);
    return base + ((start - base + 32'(4 * k)) % span);
  endfunction

  task automatic check_read(input bit exp_rv);
    check_output("rdat_valid", rdat_valid, exp_rv);
    if (exp_rv) begin
      check_output("rdat", rdat, rdata[rd_cnt]);
      check_output("rdat_last", rdat_last, rd_cnt == c_len);
      rd_cnt++;
    end
  endtask

  task automatic set_cmd(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input int len, input logic [1:0] bte);
    c_we = we; c_adr = adr; c_sel = sel; c_len = len; c_bte = bte;
    c_err_beat = 99; c_wait_lo = 0; c_wait_hi = 0; c_drop_after = -1; c_drop_len = 0;
    c_rst_beat = -1; c_spur = 0; c_hang = 0;
    for (int i = 0; i < 16; i++) begin
      wdata[i] = $urandom;
      rdata[i] = $urandom;
    end
  endtask

  task automatic do_reset_check();
    ack_i = 0; err_i = 0; wdat_valid = 0; cmd_valid = 0;
    rst = 1'b0;
    #1;
    check_output("rst_cyc", cyc_o, 0);
    check_output("rst_stb", stb_o, 0);
    check_output("rst_ready", cmd_ready, 0);
    @(posedge clk); #1;
    check_output("rst_rsp", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rel_ready0", cmd_ready, 0);
    @(negedge clk); #1;
    check_output("rel_ready1", cmd_ready, 1);
    check_output("rel_rsp", rsp_valid, 0);
  endtask

  // Runs one command end to end, acting as write-data source and bus slave
  task automatic apply_stimulus();
    int beat, words, wait_left, drop_left, stall, cycles;
    bit over, aborted, exp_rv, exp_stb, acc, errb, exp_to, exp_err, exp_ready;
    beat = 0; words = 0; drop_left = 0; stall = 0; cycles = 0; rd_cnt = 0;
    over = 0; aborted = 0; exp_rv = 0; exp_to = 0; exp_err = 0;
    wait_left = $urandom_range(c_wait_hi, c_wait_lo);
    @(negedge clk);
    cmd_valid = 1; cmd_we = c_we; cmd_adr = c_adr; cmd_sel = c_sel;
    cmd_len = 4'(c_len); cmd_bte = c_bte;
    #1 check_output("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_adr = $urandom; cmd_sel = 4'($urandom);
    while (!over && !aborted && cycles < 400) begin
      cycles++;
      if (beat == c_rst_beat) begin
        do_reset_check();
        aborted = 1;
      end else begin
        exp_stb = !c_we || (words > beat);
        if (drop_left > 0) begin
          wdat_valid = 0;
          drop_left--;
        end else begin
          wdat_valid = c_we && (words <= c_len);
        end
        wdat  = (words < 16) ? wdata[words] : 32'h0;
        ack_i = 0; err_i = 0; dat_i = $urandom;
        if (exp_stb) begin
          if (wait_left > 0) wait_left--;
          else if (beat == c_err_beat) begin err_i = 1; ack_i = 1; end
          else if (!c_hang) begin ack_i = 1; dat_i = rdata[beat]; end
        end else if (c_spur && $urandom_range(0, 1) == 1) begin
          ack_i = 1; err_i = 1'($urandom_range(0, 1));
        end
        acc  = exp_stb && ack_i && !err_i;
        errb = exp_stb && err_i;
        #1;
        check_output("cyc", cyc_o, 1);
        check_output("stb", stb_o, exp_stb);
        check_read(exp_rv);
        exp_ready = (words == beat) || acc;
        if (c_we) check_output("wdat_ready", wdat_ready, exp_ready);
        if (exp_stb && (ack_i || err_i)) begin
          check_output("adr", adr_o, exp_adr(c_adr, c_bte, beat));
          check_output("cti", cti_o, (c_len == 0) ? 3'b000 : ((beat == c_len) ? 3'b111 : 3'b010));
          check_output("bte", bte_o, (c_len == 0) ? 2'b00 : c_bte);
          check_output("sel", sel_o, c_sel);
          check_output("we", we_o, c_we);
          if (c_we) check_output("dat_o", dat_o, wdata[beat]);
        end
        if (exp_stb && !ack_i && !err_i) stall++;
        exp_to = TO_EN && stall >= TO;
        @(posedge clk);
        exp_rv = acc && !c_we;
        if (c_we && wdat_valid && exp_ready) begin
          words++;
          if (words == c_drop_after + 1) drop_left = c_drop_len;
        end
        if (acc) begin
          if (beat == c_len) over = 1;
          beat++;
          stall = 0;
          wait_left = $urandom_range(c_wait_hi, c_wait_lo);
        end
        if (errb) begin over = 1; exp_err = 1; end
        if (exp_to) over = 1;
        @(negedge clk);
      end
    end
    if (!aborted && !over) begin
      check_output("bus_budget", cycles, 0);
      @(negedge clk);
      do_reset_check();
    end else if (!aborted) begin
      ack_i = 0; err_i = 0; wdat_valid = 0;
      #1;
      check_output("resp_cyc", cyc_o, 0);
      check_output("resp_stb", stb_o, 0);
      check_output("rsp_valid", rsp_valid, 1);
      check_output("rsp_err", rsp_err, exp_err);
      check_output("rsp_timeout", rsp_timeout, exp_to);
      check_read(exp_rv);
      @(negedge clk); #1;
      check_output("rsp_one_cycle", rsp_valid, 0);
      check_output("idle_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    rst = 0; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_sel = 0; cmd_len = 0; cmd_bte = 0;
    wdat_valid = 0; wdat = 0; dat_i = 0; ack_i = 0; err_i = 0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_cyc", cyc_o, 0);
    check_output("reset_stb", stb_o, 0);
    check_output("reset_ready", cmd_ready, 0);
    check_output("reset_rsp", rsp_valid, 0);
    check_output("reset_adr", adr_o, 0);
    check_output("reset_cti", cti_o, 0);
    @(negedge clk);
    rst = 1;
    #1 check_output("release_ready0", cmd_ready, 0);
    @(negedge clk); #1;
    check_output("release_ready1", cmd_ready, 1);

    $display("[TB] single write, two wait states");
    set_cmd(1, 32'h100, 4'hF, 0, 2'b00);
    wdata[0] = 32'hDEADBEEF; c_wait_lo = 2; c_wait_hi = 2;
    apply_stimulus();

    $display("[TB] wrap-4 read from 0x10C");
    set_cmd(0, 32'h10C, 4'hF, 3, 2'b01);
    apply_stimulus();

    $display("[TB] linear write len 7 with data stall");
    set_cmd(1, 32'h0, 4'hF, 7, 2'b00);
    c_drop_after = 2; c_drop_len = 3;
    apply_stimulus();

    $display("[TB] read len 15 with error on beat 5");
    set_cmd(0, 32'h200, 4'h3, 15, 2'b00);
    c_err_beat = 5;
    apply_stimulus();

    $display("[TB] reset during beat 3");
    set_cmd(0, 32'h300, 4'hF, 7, 2'b00);
    c_rst_beat = 3;
    apply_stimulus();
    set_cmd(1, 32'h40, 4'hC, 3, 2'b10);
    apply_stimulus();

`ifdef PERIPHERAL_WB_TIMEOUT_EN
    $display("[TB] unresponsive slave");
    set_cmd(0, 32'h500, 4'hF, 3, 2'b00);
    c_hang = 1;
    apply_stimulus();
`endif

    $display("[TB] randomized commands");
    for (int n = 0; n < 24; n++) begin
      set_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 4'($urandom),
              $urandom_range(0, 15), 2'($urandom));
      c_wait_hi = 2; c_spur = 1;
      if ($urandom_range(0, 3) == 0) c_err_beat = $urandom_range(0, c_len);
      c_drop_after = $urandom_range(0, c_len);
      c_drop_len = $urandom_range(0, 3);
      apply_stimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
